// File: rtl/datapath_pkg.sv
// Shared types and constants for the 16-bit datapath: operand-fetch FSM states,
// shifter codes and the default datapath width.
package datapath_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_IMM  = 3'd1,
        RD_A    = 3'd2,
        RD_B    = 3'd3,
        ISSUE   = 3'd4,
        WAIT_WB = 3'd5
    } of_state_t;

endpackage

// File: rtl/regfile.sv
// NREGS x DATA_W register file: one synchronous write port, one combinational read port.
// With OPERAND_FETCH_RF_CLEAR_EN defined, reset also zeroes every entry.
module regfile #(
    parameter int DATA_W = datapath_pkg::DATA_W,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [NREGS];

`ifdef OPERAND_FETCH_RF_CLEAR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
`else
    // Contents survive reset; the write enable is already gated by reset upstream.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
`endif

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/operand_fetch.sv
// Multi-cycle operand-fetch stage: one command in flight, reads A then B through a single
// read port, issues them downstream, then retires the write-back. Option: OPERAND_FETCH_RF_CLEAR_EN.
module operand_fetch #(
    parameter int DATA_W = datapath_pkg::DATA_W,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_imm,
    input  logic [AW-1:0]     cmd_rn,
    input  logic [AW-1:0]     cmd_rm,
    input  logic [AW-1:0]     cmd_rd,
    input  logic [1:0]        cmd_shift,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] sh_in,
    output logic [1:0]        sh_op,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic [2:0]        dbg_state_o
);

    import datapath_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the command port accepts only in IDLE, operands transfer only in ISSUE, and
    // wb_valid is only honoured in WAIT_WB.
    of_state_t         state_q;
    logic              cmd_ready_q;
    logic              out_valid_q;
    logic [AW-1:0]     rn_q;
    logic [AW-1:0]     rm_q;
    logic [AW-1:0]     rd_q;
    logic [1:0]        shift_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    logic              rf_we;
    logic [AW-1:0]     rf_raddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    assign rf_we    = !reset && ((state_q == WR_IMM) || ((state_q == WAIT_WB) && wb_valid));
    assign rf_wdata = (state_q == WR_IMM) ? data_q : wb_data;
    assign rf_raddr = (state_q == RD_A) ? rn_q : rm_q;

    regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we_i    (rf_we),
        .waddr_i (rd_q),
        .wdata_i (rf_wdata),
        .raddr_i (rf_raddr),
        .rdata_o (rf_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            rn_q        <= '0;
            rm_q        <= '0;
            rd_q        <= '0;
            shift_q     <= SH_PASS;
            data_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        rn_q        <= cmd_rn;
                        rm_q        <= cmd_rm;
                        rd_q        <= cmd_rd;
                        shift_q     <= cmd_shift;
                        data_q      <= cmd_data;
                        cmd_ready_q <= 1'b0;
                        state_q     <= cmd_imm ? WR_IMM : RD_A;
                    end
                end
                WR_IMM: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                RD_A: begin
                    a_q     <= rf_rdata;
                    state_q <= RD_B;
                end
                RD_B: begin
                    b_q         <= rf_rdata;
                    out_valid_q <= 1'b1;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= WAIT_WB;
                    end
                end
                WAIT_WB: begin
                    if (wb_valid) begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign out_valid   = out_valid_q;
    assign a_out       = a_q;
    assign sh_in       = b_q;
    assign sh_op       = shift_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: immediate writes, operate commands, ISSUE stalls,
// mid-command resets and back-to-back commands with cmd_valid held high.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_imm;
    logic [2:0]  cmd_rn;
    logic [2:0]  cmd_rm;
    logic [2:0]  cmd_rd;
    logic [1:0]  cmd_shift;
    logic [15:0] cmd_data;
    logic [15:0] a_out;
    logic [15:0] sh_in;
    logic [1:0]  sh_op;
    logic        out_valid;
    logic        out_ready;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        busy;
    logic [2:0]  dbg_state;

    int          n_tests;
    int          n_fail;
    logic [15:0] exp_q[$];

    operand_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_imm     (cmd_imm),
        .cmd_rn      (cmd_rn),
        .cmd_rm      (cmd_rm),
        .cmd_rd      (cmd_rd),
        .cmd_shift   (cmd_shift),
        .cmd_data    (cmd_data),
        .a_out       (a_out),
        .sh_in       (sh_in),
        .sh_op       (sh_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: all driving and sampling happens on the falling edge.
    task automatic do_accept(input logic imm, input logic [2:0] rn, input logic [2:0] rm,
                             input logic [2:0] rd, input logic [1:0] sh, input logic [15:0] data);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_imm   = imm;
        cmd_rn    = rn;
        cmd_rm    = rm;
        cmd_rd    = rd;
        cmd_shift = sh;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic write_imm(input logic [2:0] rd, input logic [15:0] data);
        do_accept(1'b1, 3'd0, 3'd0, rd, 2'b00, data);
        @(negedge clk);
        check("imm_ready_cycle2", cmd_ready, 1'b1);
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic retire(input logic [15:0] data);
        wb_valid = 1'b1;
        wb_data  = data;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    // Reads a register through the datapath and writes the same value back.
    task automatic read_reg(input logic [2:0] r, output logic [15:0] a, output logic [15:0] b);
        int lat;
        do_accept(1'b0, r, r, r, 2'b00, 16'h0);
        wait_out_valid(lat);
        a = a_out;
        b = sh_in;
        handshake();
        retire(a);
    endtask

    task automatic setup_regs();
        write_imm(3'd1, 16'hF800);
        write_imm(3'd2, 16'h0381);
        write_imm(3'd3, 16'h0F00);
    endtask

    initial begin
        int          lat;
        int          acc;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] exp_r6;

        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_imm   = 1'b0;
        cmd_rn    = '0;
        cmd_rm    = '0;
        cmd_rd    = '0;
        cmd_shift = '0;
        cmd_data  = '0;
        out_ready = 1'b0;
        wb_valid  = 1'b0;
        wb_data   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sh_in", sh_in, 16'h0);
        check("rst_sh_op", sh_op, 2'b00);
        check("rst_a_out", a_out, 16'h0);
        check("rst_state", dbg_state, 3'd0);
`ifdef OPERAND_FETCH_RF_CLEAR_EN
        for (int r = 0; r < 8; r++) begin
            read_reg(r[2:0], ra, rb);
            check("rst_rf_clear", ra, 16'h0);
        end
`endif

        // Immediate timing: busy in cycle 1, ready again in cycle 2.
        do_accept(1'b1, 3'd0, 3'd0, 3'd6, 2'b00, 16'h0066);
        check("imm_busy_cycle1", busy, 1'b1);
        check("imm_ready_cycle1", cmd_ready, 1'b0);
        @(negedge clk);
        check("imm_ready_cycle2", cmd_ready, 1'b1);
        setup_regs();

        // Operate rn=rm=1, shift=LSR, rd=6; then stall in ISSUE with a stray wb pulse.
        do_accept(1'b0, 3'd1, 3'd1, 3'd6, 2'b10, 16'h0);
        wait_out_valid(lat);
        check("op_latency", lat, 3);
        check("op_a_out", a_out, 16'hF800);
        check("op_sh_in", sh_in, 16'hF800);
        check("op_sh_op", sh_op, 2'b10);
        for (int i = 0; i < 5; i++) begin
            wb_valid = (i == 2);
            wb_data  = 16'hDEAD;
            @(negedge clk);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_sh_in", sh_in, 16'hF800);
        end
        wb_valid = 1'b0;
        check("hold_sh_op", sh_op, 2'b10);
        handshake();
        check("waitwb_busy", busy, 1'b1);
        check("waitwb_out_valid", out_valid, 1'b0);

        // Reset in WAIT_WB with wb_valid: the write-back is dropped.
        reset    = 1'b1;
        wb_valid = 1'b1;
        wb_data  = 16'hBEEF;
        @(negedge clk);
        reset    = 1'b0;
        wb_valid = 1'b0;
        check("rst_wb_busy", busy, 1'b0);
        check("rst_wb_cmd_ready", cmd_ready, 1'b1);
        check("rst_wb_out_valid", out_valid, 1'b0);
        check("rst_wb_sh_op", sh_op, 2'b00);
        check("rst_wb_a_out", a_out, 16'h0);
`ifdef OPERAND_FETCH_RF_CLEAR_EN
        exp_r6 = 16'h0000;
`else
        exp_r6 = 16'h0066;
`endif
        read_reg(3'd6, ra, rb);
        check("rst_wb_r6", ra, exp_r6);
        setup_regs();

        // rd aliases rn: old operands read, write-back lands afterwards.
        do_accept(1'b0, 3'd2, 3'd3, 3'd2, 2'b00, 16'h0);
        wait_out_valid(lat);
        check("alias_latency", lat, 3);
        check("alias_a_out", a_out, 16'h0381);
        check("alias_sh_in", sh_in, 16'h0F00);
        check("alias_sh_op", sh_op, 2'b00);
        handshake();
        retire(16'h1234);
        check("retire_ready", cmd_ready, 1'b1);
        read_reg(3'd2, ra, rb);
        check("alias_r2_a", ra, 16'h1234);
        check("alias_r2_b", rb, 16'h1234);

        // Reset in RD_B abandons the command.
        do_accept(1'b0, 3'd2, 3'd3, 3'd5, 2'b01, 16'h0);
        @(negedge clk);
        check("rdb_state", dbg_state, 3'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_rdb_busy", busy, 1'b0);
        check("rst_rdb_out_valid", out_valid, 1'b0);
        check("rst_rdb_cmd_ready", cmd_ready, 1'b1);
        check("rst_rdb_sh_in", sh_in, 16'h0);
        check("rst_rdb_sh_op", sh_op, 2'b00);
        setup_regs();

        // cmd_valid held high: one accept per IDLE visit, 5-cycle command period.
        exp_q.push_back(16'hF800);
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0F00);
        acc       = 0;
        cmd_valid = 1'b1;
        cmd_imm   = 1'b0;
        cmd_rn    = 3'd1;
        cmd_rm    = 3'd1;
        cmd_rd    = 3'd4;
        cmd_shift = 2'b11;
        out_ready = 1'b1;
        wb_valid  = 1'b1;
        wb_data   = 16'hABCD;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cmd_valid && cmd_ready) acc++;
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) check("burst_sh_in", sh_in, exp_q.pop_front());
                else check("burst_extra_issue", 32'd1, 32'd0);
            end
            if (cyc == 1) cmd_rm = 3'd3;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        wb_valid  = 1'b0;
        check("burst_accepts", acc, 4);
        check("burst_issues_left", exp_q.size(), 0);
        check("burst_idle", cmd_ready, 1'b1);
        read_reg(3'd4, ra, rb);
        check("burst_r4", ra, 16'hABCD);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
